// File: rtl/apb_req_arbiter_pkg.sv
// apb_req_arbiter_pkg
// Shared definitions for the APB request arbiter:
//   - apb_arb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   - rr_pick_t       : result of a round-robin search (one-hot grant + index)
//   - rr_pick()       : round-robin search starting just after the last winner
//   - width constants used across the arbiter files
package apb_req_arbiter_pkg;

   localparam int MAX_REQ    = 16;
   localparam int IDX_WIDTH  = 4;
   localparam int PROT_WIDTH = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_arb_state_e;

   typedef struct packed {
      logic [MAX_REQ-1:0]   onehot;
      logic [IDX_WIDTH-1:0] idx;
   } rr_pick_t;

   // Walks candidates last+1 .. last+num (mod num) and returns the first one
   // whose valid bit is set. The vectors are sized for the largest supported
   // requester count, and num limits the search to the requesters that exist.
   // With no valid bit set the result is all zeros.
   function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                        input logic [IDX_WIDTH-1:0] last,
                                        input int unsigned          num);
      rr_pick_t    pick;
      int unsigned cand;
      logic        found;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_REQ; k++) begin
         cand = (32'(last) + k) % num;
         if (!found && (k <= num) && valid[cand[IDX_WIDTH-1:0]]) begin
            found                            = 1'b1;
            pick.idx                         = cand[IDX_WIDTH-1:0];
            pick.onehot[cand[IDX_WIDTH-1:0]] = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if
// APB bus between the arbiter (requester side) and the completer fabric.
//   master : drives paddr, pprot, psel, penable, pwrite, pwdata, pstrb;
//            samples pready, prdata, pslverr
//   slave  : the mirror image, used by a completer or a bench model
interface apb_req_arbiter_if
   import apb_req_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);

   logic [ADDR_WIDTH-1:0] paddr;
   logic [PROT_WIDTH-1:0] pprot;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [STRB_WIDTH-1:0] pstrb;
   logic                  pready;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pslverr;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
// Round-robin picker with a registered "last winner" pointer.
//   clk, rst  : clock and synchronous active-high reset
//   valid     : per-requester request bits
//   enable    : a grant was accepted this cycle, so advance the pointer
//   grant     : one-hot winner (combinational)
//   grant_idx : index of the winner
//   grant_any : some requester won
module apb_rr_arbiter
   import apb_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   valid,
   input  logic                 enable,
   output logic [NUM_REQ-1:0]   grant,
   output logic [IDX_WIDTH-1:0] grant_idx,
   output logic                 grant_any
);

   logic [IDX_WIDTH-1:0] last;
   rr_pick_t             pick;

   // Search starts just after the previous winner, so every requester that
   // keeps asking is served within NUM_REQ grants.
   always_comb begin
      pick      = rr_pick(MAX_REQ'(valid), last, $unsigned(NUM_REQ));
      grant     = pick.onehot[NUM_REQ-1:0];
      grant_idx = pick.idx;
      grant_any = |pick.onehot;
   end

   // The pointer resets to the highest index so requester 0 is first in line,
   // and it moves only when a grant is actually taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         last <= IDX_WIDTH'(NUM_REQ - 1);
      end else if (enable) begin
         last <= grant_idx;
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
// Shares one APB requester port among NUM_REQ internal requesters.
//   pclk, prst   : clock and synchronous active-high reset
//   req_valid    : per-requester request; req_ready is the one-hot grant
//   req_addr, req_write, req_wdata, req_strb, req_prot : packed request fields
//   rsp_valid    : one-cycle response pulse to the owning requester
//   rsp_rdata    : read data (0 on writes and on timeout)
//   rsp_slverr   : pslverr from the completer, or watchdog abort
//   rsp_timeout  : watchdog abort flag
//   apb          : APB master modport (paddr, pprot, psel, penable, pwrite,
//                  pwdata, pstrb out; pready, prdata, pslverr in)
module apb_req_arbiter
   import apb_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT    = 256
) (
   input  logic                          pclk,
   input  logic                          prst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
   input  logic [NUM_REQ*PROT_WIDTH-1:0] req_prot,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_slverr,
   output logic                          rsp_timeout,
   apb_req_arbiter_if.master             apb
);

   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   apb_arb_state_e       state;
   logic [IDX_WIDTH-1:0] owner;
   logic [WDOG_W-1:0]    wdog;
   logic [NUM_REQ-1:0]   grant;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic                 grant_any;
   logic                 handshake;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .clk       (pclk),
      .rst       (prst),
      .valid     (req_valid),
      .enable    (handshake),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Grants are only offered while idle; since the picker only selects a
   // requester whose valid is high, an offered grant is always a handshake.
   always_comb begin
      req_ready = (state == IDLE) ? grant : '0;
      handshake = (state == IDLE) && grant_any;
   end

   // Transfer sequencer. The APB outputs are the capture registers, so they
   // hold steady from SETUP through the last ACCESS cycle. The response
   // registers default to zero every cycle, which makes rsp_valid a single
   // pulse. In ACCESS, pready wins over the watchdog; the watchdog aborts the
   // transfer on the TIMEOUT-th ACCESS cycle that ends without pready.
   always_ff @(posedge pclk) begin
      if (prst) begin
         state       <= IDLE;
         owner       <= '0;
         wdog        <= '0;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.paddr   <= '0;
         apb.pwdata  <= '0;
         apb.pstrb   <= '0;
         apb.pprot   <= '0;
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         rsp_valid   <= '0;
         rsp_rdata   <= '0;
         rsp_slverr  <= 1'b0;
         rsp_timeout <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_any) begin
                  owner       <= grant_idx;
                  apb.paddr   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  apb.pwrite  <= req_write[grant_idx];
                  apb.pwdata  <= req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                  apb.pstrb   <= req_write[grant_idx] ?
                                 req_strb[grant_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
                  apb.pprot   <= req_prot[grant_idx*PROT_WIDTH +: PROT_WIDTH];
                  apb.psel    <= 1'b1;
                  apb.penable <= 1'b0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               apb.penable <= 1'b1;
               wdog        <= '0;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (apb.pready) begin
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  rsp_valid   <= NUM_REQ'(1) << owner;
                  rsp_rdata   <= apb.pwrite ? '0 : apb.prdata;
                  rsp_slverr  <= apb.pslverr;
                  state       <= IDLE;
               end else if (wdog == WDOG_W'(TIMEOUT - 1)) begin
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  rsp_valid   <= NUM_REQ'(1) << owner;
                  rsp_slverr  <= 1'b1;
                  rsp_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  wdog <= wdog + WDOG_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter
// Directed bench for apb_req_arbiter with four requesters and TIMEOUT=8.
// Inputs change 1 ns after the rising edge; outputs are checked there too,
// and the combinational grant is checked 1 ns after the inputs change.
module tb_apb_req_arbiter;
   import apb_req_arbiter_pkg::*;

   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = 4;
   localparam int TIMEOUT    = 8;

   logic                          pclk = 1'b0;
   logic                          prst;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_write;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
   logic [NUM_REQ*PROT_WIDTH-1:0] req_prot;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic                          rsp_slverr;
   logic                          rsp_timeout;

   int tests_run    = 0;
   int tests_failed = 0;

   apb_req_arbiter_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) apb ();

   apb_req_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .pclk        (pclk),
      .prst        (prst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_write   (req_write),
      .req_wdata   (req_wdata),
      .req_strb    (req_strb),
      .req_prot    (req_prot),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_slverr  (rsp_slverr),
      .rsp_timeout (rsp_timeout),
      .apb         (apb)
   );

   // Free-running 100 MHz clock.
   always #5 pclk = ~pclk;

   // Advance a number of rising edges and settle 1 ns past the last one.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge pclk);
      #1;
   endtask

   // One counted comparison against a hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Load one requester's request fields.
   task automatic setReq(input int i, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot);
      req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = addr;
      req_write[i]                          = wr;
      req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = wdata;
      req_strb[i*STRB_WIDTH +: STRB_WIDTH]  = strb;
      req_prot[i*PROT_WIDTH +: PROT_WIDTH]  = prot;
   endtask

   // Directed scenario sequence.
   initial begin
      int exp_w;

      prst        = 1'b1;
      req_valid   = '0;
      req_addr    = '0;
      req_write   = '0;
      req_wdata   = '0;
      req_strb    = '0;
      req_prot    = '0;
      apb.pready  = 1'b0;
      apb.prdata  = '0;
      apb.pslverr = 1'b0;

      // Reset held for three cycles: everything reads zero.
      applyStimulus(3);
      checkOutput("rst_psel",    32'(apb.psel),    32'h0);
      checkOutput("rst_penable", 32'(apb.penable), 32'h0);
      checkOutput("rst_pwrite",  32'(apb.pwrite),  32'h0);
      checkOutput("rst_paddr",   32'(apb.paddr),   32'h0);
      checkOutput("rst_pwdata",  32'(apb.pwdata),  32'h0);
      checkOutput("rst_pstrb",   32'(apb.pstrb),   32'h0);
      checkOutput("rst_pprot",   32'(apb.pprot),   32'h0);
      checkOutput("rst_ready",   32'(req_ready),   32'h0);
      checkOutput("rst_rspv",    32'(rsp_valid),   32'h0);
      checkOutput("rst_rdata",   32'(rsp_rdata),   32'h0);
      checkOutput("rst_slverr",  32'(rsp_slverr),  32'h0);
      checkOutput("rst_tmo",     32'(rsp_timeout), 32'h0);
      prst = 1'b0;
      applyStimulus(1);
      checkOutput("idle_psel", 32'(apb.psel), 32'h0);

      // Single write from requester 2; pready already high in SETUP is ignored.
      setReq(2, 32'h40, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010);
      req_valid = 4'b0100;
      #1;
      checkOutput("wr_ready", 32'(req_ready), 32'h4);
      applyStimulus(1);
      req_valid  = '0;
      apb.pready = 1'b1;
      checkOutput("wr_setup_psel",    32'(apb.psel),    32'h1);
      checkOutput("wr_setup_penable", 32'(apb.penable), 32'h0);
      checkOutput("wr_paddr",         32'(apb.paddr),   32'h40);
      checkOutput("wr_pwdata",        32'(apb.pwdata),  32'hDEADBEEF);
      checkOutput("wr_pstrb",         32'(apb.pstrb),   32'hF);
      checkOutput("wr_pwrite",        32'(apb.pwrite),  32'h1);
      checkOutput("wr_pprot",         32'(apb.pprot),   32'h2);
      applyStimulus(1);
      checkOutput("wr_access_psel",    32'(apb.psel),    32'h1);
      checkOutput("wr_access_penable", 32'(apb.penable), 32'h1);
      checkOutput("wr_access_rspv",    32'(rsp_valid),   32'h0);
      applyStimulus(1);
      apb.pready = 1'b0;
      checkOutput("wr_done_psel", 32'(apb.psel),    32'h0);
      checkOutput("wr_rspv",      32'(rsp_valid),   32'h4);
      checkOutput("wr_slverr",    32'(rsp_slverr),  32'h0);
      checkOutput("wr_tmo",       32'(rsp_timeout), 32'h0);
      checkOutput("wr_rdata",     32'(rsp_rdata),   32'h0);
      applyStimulus(1);
      checkOutput("wr_rspv_pulse", 32'(rsp_valid), 32'h0);

      // Round-robin from a fresh reset: four reads always pending, zero-wait.
      prst = 1'b1;
      applyStimulus(1);
      prst = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         setReq(i, 32'h100 + 32'(4*i), 1'b0, 32'hFFFF0000 + 32'(i), 4'hF, 3'(i));
      end
      req_valid  = 4'b1111;
      apb.pready = 1'b1;
      for (int g = 0; g < 5; g++) begin
         exp_w = g % 4;
         #1;
         checkOutput($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1 << exp_w));
         applyStimulus(1);
         apb.prdata = 32'h1000 + 32'(g);
         checkOutput($sformatf("rr_setup%0d", g), 32'(apb.penable), 32'h0);
         checkOutput($sformatf("rr_paddr%0d", g), 32'(apb.paddr), 32'h100 + 32'(4*exp_w));
         checkOutput($sformatf("rr_pstrb%0d", g), 32'(apb.pstrb), 32'h0);
         applyStimulus(1);
         checkOutput($sformatf("rr_access%0d", g), 32'(apb.penable), 32'h1);
         applyStimulus(1);
         checkOutput($sformatf("rr_rspv%0d", g),  32'(rsp_valid), 32'(1 << exp_w));
         checkOutput($sformatf("rr_rdata%0d", g), 32'(rsp_rdata), 32'h1000 + 32'(g));
      end
      req_valid  = '0;
      apb.pready = 1'b0;

      // Read from requester 1 with five wait states and a slave error.
      setReq(1, 32'h80, 1'b0, 32'h0, 4'hF, 3'b000);
      req_valid = 4'b0010;
      #1;
      checkOutput("ws_ready", 32'(req_ready), 32'h2);
      applyStimulus(1);
      req_valid = '0;
      applyStimulus(1);
      for (int k = 1; k <= 5; k++) begin
         checkOutput($sformatf("ws_wait%0d_penable", k), 32'(apb.penable), 32'h1);
         checkOutput($sformatf("ws_wait%0d_rspv", k),    32'(rsp_valid),   32'h0);
         applyStimulus(1);
      end
      apb.pready  = 1'b1;
      apb.prdata  = 32'h1234;
      apb.pslverr = 1'b1;
      checkOutput("ws_last_penable", 32'(apb.penable), 32'h1);
      applyStimulus(1);
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      checkOutput("ws_rspv",   32'(rsp_valid),   32'h2);
      checkOutput("ws_rdata",  32'(rsp_rdata),   32'h1234);
      checkOutput("ws_slverr", 32'(rsp_slverr),  32'h1);
      checkOutput("ws_tmo",    32'(rsp_timeout), 32'h0);
      checkOutput("ws_psel",   32'(apb.psel),    32'h0);

      // Watchdog abort: requester 3, pready never arrives.
      setReq(3, 32'hC0, 1'b0, 32'h0, 4'hF, 3'b001);
      req_valid = 4'b1000;
      #1;
      checkOutput("to_ready", 32'(req_ready), 32'h8);
      applyStimulus(1);
      req_valid  = '0;
      apb.prdata = 32'hFFFF;
      applyStimulus(1);
      for (int k = 1; k <= TIMEOUT; k++) begin
         checkOutput($sformatf("to_wait%0d_psel", k), 32'(apb.psel), 32'h1);
         applyStimulus(1);
      end
      checkOutput("to_psel",    32'(apb.psel),    32'h0);
      checkOutput("to_penable", 32'(apb.penable), 32'h0);
      checkOutput("to_rspv",    32'(rsp_valid),   32'h8);
      checkOutput("to_slverr",  32'(rsp_slverr),  32'h1);
      checkOutput("to_tmo",     32'(rsp_timeout), 32'h1);
      checkOutput("to_rdata",   32'(rsp_rdata),   32'h0);

      // A normal write right after the abort, in the response cycle.
      setReq(0, 32'h10, 1'b1, 32'h55, 4'h3, 3'b000);
      req_valid = 4'b0001;
      #1;
      checkOutput("post_to_ready", 32'(req_ready), 32'h1);
      applyStimulus(1);
      req_valid  = '0;
      apb.pready = 1'b1;
      checkOutput("post_to_pstrb", 32'(apb.pstrb), 32'h3);
      applyStimulus(2);
      apb.pready = 1'b0;
      checkOutput("post_to_rspv", 32'(rsp_valid),   32'h1);
      checkOutput("post_to_tmo",  32'(rsp_timeout), 32'h0);

      // pready on the very cycle the watchdog would expire: normal completion.
      setReq(1, 32'h84, 1'b0, 32'h0, 4'hF, 3'b000);
      req_valid = 4'b0010;
      #1;
      checkOutput("edge_ready", 32'(req_ready), 32'h2);
      applyStimulus(1);
      req_valid = '0;
      applyStimulus(1 + (TIMEOUT - 1));
      checkOutput("edge_penable", 32'(apb.penable), 32'h1);
      apb.pready = 1'b1;
      apb.prdata = 32'hBEEF;
      applyStimulus(1);
      apb.pready = 1'b0;
      checkOutput("edge_rspv",   32'(rsp_valid),   32'h2);
      checkOutput("edge_tmo",    32'(rsp_timeout), 32'h0);
      checkOutput("edge_slverr", 32'(rsp_slverr),  32'h0);
      checkOutput("edge_rdata",  32'(rsp_rdata),   32'hBEEF);

      // Reset during ACCESS wait states, then arbitration restarts at 0.
      setReq(2, 32'h48, 1'b0, 32'h0, 4'hF, 3'b000);
      req_valid = 4'b0100;
      #1;
      checkOutput("mid_ready", 32'(req_ready), 32'h4);
      applyStimulus(1);
      req_valid = '0;
      applyStimulus(2);
      checkOutput("mid_access_penable", 32'(apb.penable), 32'h1);
      prst = 1'b1;
      applyStimulus(1);
      prst = 1'b0;
      checkOutput("mid_psel",    32'(apb.psel),    32'h0);
      checkOutput("mid_penable", 32'(apb.penable), 32'h0);
      checkOutput("mid_rspv",    32'(rsp_valid),   32'h0);
      req_valid = 4'b1111;
      #1;
      checkOutput("mid_regrant", 32'(req_ready), 32'h1);
      applyStimulus(1);
      req_valid = '0;
      checkOutput("mid_regrant_paddr", 32'(apb.paddr), 32'h10);
      checkOutput("mid_no_rsp",        32'(rsp_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
